// File: rtl/fifo_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_pkg
//  Description : Shared types for the FIFO read-side stream adapter. The
//                buffer state doubles as the buffered-word count.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_stream_pkg;

    // Width of the buffered-word count (0..2)
    localparam int LEVEL_WIDTH = 2;

    // Buffer occupancy; encoding equals the number of words held
    typedef enum logic [LEVEL_WIDTH-1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`ifndef FIFO_STREAM_READER_SV
`define FIFO_STREAM_READER_SV
`default_nettype none
// ============================================================================
//  Module      : fifo_stream_reader
//  Description : Drains a show-ahead FIFO read port into a registered
//                valid/ready stream through a two-word skid buffer. The FIFO
//                pop depends only on registered state, so downstream ready
//                never reaches the FIFO combinationally. Provides synchronous
//                flush and a free-running accepted-transfer counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   i_clock,
    input  logic                   i_areset,
    input  logic [DATA_WIDTH-1:0]  i_fifo_data,
    input  logic                   i_fifo_empty,
    output logic                   o_fifo_rd_en,
    input  logic                   i_flush,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [LEVEL_WIDTH-1:0] o_level,
    output logic [COUNT_WIDTH-1:0] o_xfer_count
);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_head;
    logic [DATA_WIDTH-1:0]   w_head_nxt;
    logic [DATA_WIDTH-1:0]   r_skid;
    logic [DATA_WIDTH-1:0]   w_skid_nxt;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic                    w_push;
    logic                    w_take;

    // Pop only when room exists; reset gates the strobe so no word is lost
    // from the FIFO while the buffer is held cleared.
    assign o_fifo_rd_en = !i_fifo_empty && (r_state != BUF_TWO) && !i_flush && !i_areset;

    assign w_push       = o_fifo_rd_en;
    assign o_valid      = (r_state != BUF_EMPTY);
    assign w_take       = o_valid && i_ready;
    assign o_data       = r_head;
    assign o_level      = r_state;
    assign o_xfer_count = r_count;

    // State, head and skid registers
    always_ff @(posedge i_clock or posedge i_areset) begin
        if (i_areset) begin
            r_state <= BUF_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    // Next-state and head/skid muxing; flush overrides every transition but
    // leaves the data registers untouched since o_data is don't-care then.
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_skid_nxt  = r_skid;
        if (i_flush) begin
            w_state_nxt = BUF_EMPTY;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = BUF_ONE;
                        w_head_nxt  = i_fifo_data;
                    end
                end
                BUF_ONE: begin
                    if (w_push && w_take) begin
                        w_head_nxt  = i_fifo_data;
                    end else if (w_push) begin
                        w_state_nxt = BUF_TWO;
                        w_skid_nxt  = i_fifo_data;
                    end else if (w_take) begin
                        w_state_nxt = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    // No pop is issued here, so only a take can move us
                    if (w_take) begin
                        w_state_nxt = BUF_ONE;
                        w_head_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = BUF_EMPTY;
                end
            endcase
        end
    end

    // Accepted-transfer counter; counts takes even during a flush cycle
    always_ff @(posedge i_clock or posedge i_areset) begin
        if (i_areset) begin
            r_count <= '0;
        end else if (w_take) begin
            r_count <= r_count + COUNT_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire
`endif

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_stream_reader
//  Description : Directed self-checking bench for fifo_stream_reader. A
//                pointer-based show-ahead FIFO model feeds the main instance;
//                a second instance with a 4-bit counter checks wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        flush;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic [1:0]  level;
    logic [15:0] xfer;

    logic        rd_en4;
    logic [7:0]  data4;
    logic        valid4;
    logic        ready4;
    logic [1:0]  level4;
    logic [3:0]  xfer4;

    logic [7:0]  mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clk = ~clk;

    // Show-ahead FIFO model: head word visible whenever non-empty
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr & 63];

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) rd_ptr <= rd_ptr + 1;
    end

    fifo_stream_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
        .i_clock      (clk),
        .i_areset     (rst),
        .i_fifo_data  (fifo_data),
        .i_fifo_empty (fifo_empty),
        .o_fifo_rd_en (fifo_rd_en),
        .i_flush      (flush),
        .o_data       (data),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_level      (level),
        .o_xfer_count (xfer)
    );

    // Always-non-empty source with a 4-bit counter for the wrap check
    fifo_stream_reader #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut4 (
        .i_clock      (clk),
        .i_areset     (rst),
        .i_fifo_data  (8'h5A),
        .i_fifo_empty (1'b0),
        .o_fifo_rd_en (rd_en4),
        .i_flush      (1'b0),
        .o_data       (data4),
        .o_valid      (valid4),
        .i_ready      (ready4),
        .o_level      (level4),
        .o_xfer_count (xfer4)
    );

    task automatic push_word(input logic [7:0] d);
        mem[wr_ptr & 63] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b0; flush = 1'b0; ready4 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", valid); end
        tests_run++; if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en: got %0b want 0", fifo_rd_en); end
        tests_run++; if (level !== 2'd0) begin tests_failed++; $display("FAIL reset_level: got %0d want 0", level); end
        tests_run++; if (xfer !== 16'd0) begin tests_failed++; $display("FAIL reset_xfer: got %0d want 0", xfer); end
        tests_run++; if (data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", data); end
    endtask

    task automatic test_streaming();
        logic [7:0] exp;
        ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(8'(i));
        for (int i = 0; i < 8; i++) begin
            #1;
            tests_run++; if (fifo_rd_en !== 1'b1) begin tests_failed++; $display("FAIL stream_pop[%0d]: got %0b want 1", i, fifo_rd_en); end
            @(negedge clk);
            exp = 8'(i + 1);
            tests_run++; if (valid !== 1'b1 || data !== exp) begin tests_failed++; $display("FAIL stream_data[%0d]: got v=%0b d=%h want v=1 d=%h", i, valid, data, exp); end
        end
        #1;
        tests_run++; if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL stream_pop_end: got %0b want 0", fifo_rd_en); end
        @(negedge clk);
        tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL stream_drained: got %0b want 0", valid); end
        tests_run++; if (xfer !== 16'd8) begin tests_failed++; $display("FAIL stream_xfer: got %0d want 8", xfer); end
    endtask

    task automatic test_backpressure();
        int         p0;
        int         n;
        logic [7:0] got [0:5];
        logic [7:0] exp;
        ready = 1'b0;
        p0 = rd_ptr;
        for (int i = 0; i < 6; i++) push_word(8'hA0 + 8'(i));
        repeat (6) @(negedge clk);
        tests_run++; if (rd_ptr - p0 !== 2) begin tests_failed++; $display("FAIL bp_pops: got %0d want 2", rd_ptr - p0); end
        tests_run++; if (level !== 2'd2) begin tests_failed++; $display("FAIL bp_level: got %0d want 2", level); end
        tests_run++; if (valid !== 1'b1 || data !== 8'hA0) begin tests_failed++; $display("FAIL bp_hold: got v=%0b d=%h want v=1 d=a0", valid, data); end
        #1;
        tests_run++; if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL bp_no_pop: got %0b want 0", fifo_rd_en); end
        @(negedge clk);
        ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 6; c++) begin
            if (valid) begin got[n] = data; n++; end
            @(negedge clk);
        end
        tests_run++; if (n !== 6) begin tests_failed++; $display("FAIL bp_count: got %0d words want 6", n); end
        for (int k = 0; k < n; k++) begin
            exp = 8'hA0 + 8'(k);
            tests_run++; if (got[k] !== exp) begin tests_failed++; $display("FAIL bp_order[%0d]: got %h want %h", k, got[k], exp); end
        end
        tests_run++; if (valid !== 1'b0 || xfer !== 16'd14) begin tests_failed++; $display("FAIL bp_drain: got v=%0b xfer=%0d want v=0 xfer=14", valid, xfer); end
        ready = 1'b0;
    endtask

    task automatic test_flush();
        int p0;
        ready = 1'b0;
        push_word(8'h11); push_word(8'h22); push_word(8'h33);
        repeat (3) @(negedge clk);
        tests_run++; if (level !== 2'd2 || data !== 8'h11) begin tests_failed++; $display("FAIL flush_pre: got lvl=%0d d=%h want lvl=2 d=11", level, data); end
        p0 = rd_ptr;
        flush = 1'b1;
        #1;
        tests_run++; if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL flush_no_pop: got %0b want 0", fifo_rd_en); end
        @(negedge clk);
        flush = 1'b0;
        tests_run++; if (level !== 2'd0 || valid !== 1'b0) begin tests_failed++; $display("FAIL flush_empty: got lvl=%0d v=%0b want lvl=0 v=0", level, valid); end
        tests_run++; if (rd_ptr !== p0) begin tests_failed++; $display("FAIL flush_ptr: got %0d pops want 0", rd_ptr - p0); end
        @(negedge clk);
        tests_run++; if (valid !== 1'b1 || data !== 8'h33) begin tests_failed++; $display("FAIL flush_next: got v=%0b d=%h want v=1 d=33", valid, data); end
        // Flush coinciding with a take: the transfer still counts
        ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        ready = 1'b0; flush = 1'b0;
        tests_run++; if (xfer !== 16'd15 || valid !== 1'b0) begin tests_failed++; $display("FAIL flush_take: got xfer=%0d v=%0b want xfer=15 v=0", xfer, valid); end
    endtask

    task automatic test_async_reset();
        ready = 1'b0;
        push_word(8'hB0); push_word(8'hB1); push_word(8'hB2);
        repeat (3) @(negedge clk);
        tests_run++; if (level !== 2'd2) begin tests_failed++; $display("FAIL areset_pre: got lvl=%0d want 2", level); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (valid !== 1'b0 || level !== 2'd0) begin tests_failed++; $display("FAIL areset_state: got v=%0b lvl=%0d want 0 0", valid, level); end
        tests_run++; if (xfer !== 16'd0 || data !== 8'h00) begin tests_failed++; $display("FAIL areset_regs: got xfer=%0d d=%h want 0 00", xfer, data); end
        tests_run++; if (fifo_rd_en !== 1'b0) begin tests_failed++; $display("FAIL areset_rd_en: got %0b want 0", fifo_rd_en); end
        repeat (2) begin
            @(negedge clk);
            tests_run++; if (fifo_rd_en !== 1'b0 || valid !== 1'b0) begin tests_failed++; $display("FAIL areset_hold: got rd=%0b v=%0b want 0 0", fifo_rd_en, valid); end
        end
        tests_run++; if (wr_ptr - rd_ptr !== 1) begin tests_failed++; $display("FAIL areset_fifo: got %0d left want 1", wr_ptr - rd_ptr); end
        rst = 1'b0;
    endtask

    task automatic test_count_wrap();
        repeat (3) @(negedge clk);
        tests_run++; if (xfer4 !== 4'd0 || level4 !== 2'd2) begin tests_failed++; $display("FAIL wrap_pre: got xfer=%0d lvl=%0d want 0 2", xfer4, level4); end
        tests_run++; if (rd_en4 !== 1'b0 || valid4 !== 1'b1 || data4 !== 8'h5A) begin tests_failed++; $display("FAIL wrap_full: got rd=%0b v=%0b d=%h want 0 1 5a", rd_en4, valid4, data4); end
        ready4 = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        tests_run++; if (xfer4 !== 4'd0) begin tests_failed++; $display("FAIL wrap_16: got %0d want 0", xfer4); end
        @(posedge clk);
        #1 ready4 = 1'b0;
        tests_run++; if (xfer4 !== 4'd1) begin tests_failed++; $display("FAIL wrap_17: got %0d want 1", xfer4); end
        @(negedge clk);
        tests_run++; if (xfer4 !== 4'd1) begin tests_failed++; $display("FAIL wrap_hold: got %0d want 1", xfer4); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
